simd_result_unpacker: RTL and testbench
=======================================

Name: simd_result_unpacker

Overview:
- Consumes the packed 48-bit SIMD ALU result S, its per-segment carry pairs and COUT.
- Splits the word into per-lane results according to USE_SIMD and emits them one lane per handshake, lane 0 first.
- Each lane is emitted with its carry folded in as an exact wide value.
- Sits directly after the PIRDSP ALU stage; the ALU packs lanes into segments, this block reads them back out.

Parameters:
- DATA_W, 48, packed result width; fixed segment map below requires 48.
- OUT_W, 50, emitted lane width: widest lane (48) plus 2 carry bits.
- CNT_W, 8, width of the overflow counter (optional feature only).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  packed word valid.
- in_ready  output  1  block can accept a word.
- in_use_simd  input  2  mode: 00 = 27x18, 01 = 9x9, 10 = 4x4, 11 = 2x2.
- in_s  input  48  packed ALU result S.
- in_carry  input  16  result_SIMD_carry_out; pair k = bits [2k+1:2k].
- in_cout  input  1  ALU COUT.
- out_valid  output  1  lane valid.
- out_ready  input  1  downstream accepts the lane.
- out_data  output  OUT_W  lane value plus carry, zero-extended.
- out_lane  output  3  lane index.
- out_last  output  1  final lane of the word.
- ovf_count  output  CNT_W  only with SIMD_UNPACK_OVF_CNT_EN.

Behaviour:
- Segment bit boundaries: 0, 13, 17, 23, 27, 31, 35, 41, 45, 48.
- Lane map by mode:
  - 00: 1 lane [47:0], carry = in_cout.
  - 01: 2 lanes. [26:0] uses pair 3; [47:27] uses cout.
  - 10: 4 lanes. [16:0] uses pair 1; [26:17] pair 3; [34:27] pair 5; [47:35] cout.
  - 11: 8 lanes. Lane k<7 = segment k, carry from pair k; lane 7 = [47:41], carry from cout.
- Lane value: carry = pair[1] + pair[0] (0..2); for cout lanes carry = cout. out_data = zext(lane bits) + (carry << lane_width).
- States:
  - IDLE: in_ready=1. in_valid&in_ready captures S, carry, cout and mode into registers, clears the lane counter, and moves to EMIT.
  - EMIT: out_valid=1, driven from the registered word only. out_valid&out_ready advances the lane.
  - After the last lane is accepted, the block returns to IDLE.
- Back-to-back: in_ready is also high in EMIT when out_last&out_ready. A word captured that cycle starts at lane 0 next cycle, with no bubble.
- Latency: first lane is valid the cycle after capture.
- Throughput: one lane per cycle with out_ready held high.
- Output stability: out_* hold stable while out_valid&!out_ready.
- Input stability: the captured word is unaffected by input changes during EMIT.
- Reset, any time: state=IDLE, counter=0, out_valid=0, out_data=0, out_lane=0, out_last=0, in_ready=1 after release, ovf_count=0. A word in flight is dropped.

Optional Feature:
- Macro: SIMD_UNPACK_OVF_CNT_EN.
- Defined: ovf_count increments on each accepted lane whose carry is non-zero. It saturates at all-ones and clears on reset.
- Undefined: ovf_count port and its logic are absent.

Decomposition:
- Shared package pirdsp_simd_pkg holds:
  - mode encodings (MODE_27X18, MODE_SUM_9X9, MODE_SUM_4X4, MODE_SUM_2X2);
  - the segment boundary constant array;
  - a lane-count function per mode (1/2/4/8).
- Sub-module simd_lane_extract (combinational): takes mode, lane index, S, carry and cout; returns the lane's out_data and a last flag. The top keeps the FSM, the registers and the handshake.

Test Plan:
- Mode 00, S=48'hFFFF_FFFF_FFFF, cout=1 -> one lane: out_data=50'h1_FFFF_FFFF_FFFF, out_lane=0, out_last=1.
- Mode 01, S[26:0]=27'h7FF_FFFF, pair3=2'b11, S[47:27]=21'h00005, cout=0 -> lane0 = 0x17FF_FFFF; lane1 = 5 with out_last=1.
- Mode 11, S=48'h0123_4567_89AB, carries 0, out_ready toggling 1/0 -> 8 lanes = each segment slice in order, stable while stalled, out_last on lane 7.
- Mode 10, words back-to-back, out_ready=1 -> second word's lane0 appears the cycle after the first word's lane3, with no gap.
- Reset asserted during lane 2 of a mode-11 word -> out_valid=0 at once; after release, the next word starts at lane 0.
- With SIMD_UNPACK_OVF_CNT_EN, 300 mode-00 words with cout=1 -> ovf_count saturates at 8'hFF.

Source files
------------

// File: rtl/pirdsp_simd_pkg.sv
// pirdsp_simd_pkg: SIMD mode encodings, ALU segment boundaries and lane-count helper
package pirdsp_simd_pkg;

    typedef enum logic [1:0] {
        MODE_27X18   = 2'b00,
        MODE_SUM_9X9 = 2'b01,
        MODE_SUM_4X4 = 2'b10,
        MODE_SUM_2X2 = 2'b11
    } simd_mode_e;

    typedef enum logic {IDLE, EMIT} unpack_state_e;

    localparam int SEG_BOUND [10] = '{0, 13, 17, 23, 27, 31, 35, 41, 45, 48};

    function automatic logic [3:0] lane_count(input simd_mode_e m);
        return 4'd1 << m;
    endfunction

endpackage

// File: rtl/simd_lane_extract.sv
// simd_lane_extract: slices one lane out of the packed word and folds its carry in.
// SIMD_UNPACK_OVF_CNT_EN adds the has_carry flag used by the overflow counter.
module simd_lane_extract
    import pirdsp_simd_pkg::*;
#(
    parameter int DATA_W = 48,
    parameter int OUT_W  = 50
) (
    input  logic              mode_ok,
    input  simd_mode_e        mode,
    input  logic [2:0]        lane,
    input  logic [DATA_W-1:0] s,
    input  logic [15:0]       carry,
    input  logic              cout,
    output logic [OUT_W-1:0]  data,
`ifdef SIMD_UNPACK_OVF_CNT_EN
    output logic              has_carry,
`endif
    output logic              last
);

    logic [3:0]       step;
    logic [3:0]       lo_idx;
    logic [3:0]       hi_idx;
    logic [3:0]       pair_idx;
    logic [5:0]       lo;
    logic [5:0]       w;
    logic [15:0]      pr;
    logic [1:0]       c;
    logic [OUT_W-1:0] mask;

    // Lane k of an n-lane mode spans segments [k*8/n, (k+1)*8/n); the last lane runs to the top bit
    always_comb begin
        step     = 4'd8 >> mode;
        last     = {1'b0, lane} == lane_count(mode) - 4'd1;
        lo_idx   = {1'b0, lane} * step;
        hi_idx   = lo_idx + step;
        pair_idx = hi_idx - 4'd1;
        lo       = 6'(SEG_BOUND[lo_idx]);
        w        = (last ? 6'(DATA_W) : 6'(SEG_BOUND[hi_idx])) - lo;
        pr       = carry >> {pair_idx, 1'b0};
        c        = last ? {1'b0, cout} : {1'b0, pr[1]} + {1'b0, pr[0]};
        mask     = {OUT_W{1'b1}} >> (OUT_W - int'(w));
        data     = mode_ok ? (OUT_W'(s >> lo) & mask) + (OUT_W'(c) << w) : '0;
    end

`ifdef SIMD_UNPACK_OVF_CNT_EN
    assign has_carry = |c;
`endif

endmodule

// File: rtl/simd_result_unpacker.sv
// simd_result_unpacker: emits the lanes of a packed SIMD ALU result one per handshake, lane 0 first.
// SIMD_UNPACK_OVF_CNT_EN adds ovf_count, a saturating count of emitted lanes with non-zero carry.
module simd_result_unpacker
    import pirdsp_simd_pkg::*;
#(
    parameter int DATA_W = 48,
`ifdef SIMD_UNPACK_OVF_CNT_EN
    parameter int CNT_W  = 8,
`endif
    parameter int OUT_W  = 50
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_use_simd,
    input  logic [DATA_W-1:0] in_s,
    input  logic [15:0]       in_carry,
    input  logic              in_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [2:0]        out_lane,
`ifdef SIMD_UNPACK_OVF_CNT_EN
    output logic [CNT_W-1:0]  ovf_count,
`endif
    output logic              out_last
);

    unpack_state_e     state;
    unpack_state_e     state_n;
    logic [2:0]        lane;
    logic [2:0]        lane_n;
    simd_mode_e        mode_q;
    logic [DATA_W-1:0] s_q;
    logic [15:0]       carry_q;
    logic              cout_q;
    logic              ext_last;
    logic              accept;
    logic              lane_done;
`ifdef SIMD_UNPACK_OVF_CNT_EN
    logic              has_carry;
`endif

    simd_lane_extract #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_extract (
        .mode_ok   (out_valid),
        .mode      (mode_q),
        .lane      (lane),
        .s         (s_q),
        .carry     (carry_q),
        .cout      (cout_q),
        .data      (out_data),
`ifdef SIMD_UNPACK_OVF_CNT_EN
        .has_carry (has_carry),
`endif
        .last      (ext_last)
    );

    assign out_valid = state == EMIT;
    assign out_lane  = lane;
    assign out_last  = out_valid & ext_last;
    assign lane_done = out_valid & out_ready;
    // Accepting on the final lane lets the next word follow without a bubble
    assign in_ready  = (state == IDLE) | (out_last & out_ready);
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_n = state;
        lane_n  = lane;
        if (accept) begin
            state_n = EMIT;
            lane_n  = '0;
        end else if (lane_done) begin
            state_n = ext_last ? IDLE : EMIT;
            lane_n  = ext_last ? '0 : lane + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            lane    <= '0;
            mode_q  <= MODE_27X18;
            s_q     <= '0;
            carry_q <= '0;
            cout_q  <= 1'b0;
        end else begin
            state <= state_n;
            lane  <= lane_n;
            if (accept) begin
                mode_q  <= simd_mode_e'(in_use_simd);
                s_q     <= in_s;
                carry_q <= in_carry;
                cout_q  <= in_cout;
            end
        end
    end

`ifdef SIMD_UNPACK_OVF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf_count <= '0;
        else if (lane_done && has_carry && !(&ovf_count))
            ovf_count <= ovf_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_simd_result_unpacker.sv
// tb_simd_result_unpacker: directed vectors with hand-computed lane values.
module tb_simd_result_unpacker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_use_simd = '0;
    logic [47:0] in_s = '0;
    logic [15:0] in_carry = '0;
    logic        in_cout = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [49:0] out_data;
    logic [2:0]  out_lane;
    logic        out_last;
`ifdef SIMD_UNPACK_OVF_CNT_EN
    logic [7:0]  ovf_count;
`endif

    int total = 0;
    int bad = 0;

    logic [49:0] seg_exp [8] = '{50'h9AB, 50'hC, 50'h33, 50'hA, 50'h8, 50'h6, 50'h24, 50'h0};
    logic [49:0] m10_exp [4] = '{50'h3FFFF, 50'h7FF, 50'h2FF, 50'h3FFF};

    simd_result_unpacker dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_use_simd (in_use_simd),
        .in_s        (in_s),
        .in_carry    (in_carry),
        .in_cout     (in_cout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_lane    (out_lane),
`ifdef SIMD_UNPACK_OVF_CNT_EN
        .ovf_count   (ovf_count),
`endif
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] m, input logic [47:0] s, input logic [15:0] c, input logic co);
        in_use_simd = m;
        in_s        = s;
        in_carry    = c;
        in_cout     = co;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid    = 1'b0;
        in_s        = ~s;
        in_carry    = ~c;
        in_cout     = ~co;
        in_use_simd = ~m;
    endtask

    initial begin
        @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_lane", 64'(out_lane), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(in_ready), 64'd1);
`ifdef SIMD_UNPACK_OVF_CNT_EN
        check("rst_ovf", 64'(ovf_count), 64'd0);
`endif
        // mode 00: single 48-bit lane with cout
        push(2'b00, 48'hFFFF_FFFF_FFFF, 16'h0000, 1'b1);
        check("m00_valid", 64'(out_valid), 64'd1);
        check("m00_data", 64'(out_data), 64'h1_FFFF_FFFF_FFFF);
        check("m00_lane", 64'(out_lane), 64'd0);
        check("m00_last", 64'(out_last), 64'd1);
        @(negedge clk);
        check("m00_done", 64'(out_valid), 64'd0);
        // mode 01: pair3 = 11 adds 2 above bit 27
        push(2'b01, 48'h0000_2FFF_FFFF, 16'h00C0, 1'b0);
        check("m01_l0_data", 64'(out_data), 64'h17FF_FFFF);
        check("m01_l0_last", 64'(out_last), 64'd0);
        check("m01_l0_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("m01_l1_data", 64'(out_data), 64'd5);
        check("m01_l1_lane", 64'(out_lane), 64'd1);
        check("m01_l1_last", 64'(out_last), 64'd1);
        @(negedge clk);
        check("m01_done", 64'(out_valid), 64'd0);
        // mode 11 with out_ready toggling
        push(2'b11, 48'h0123_4567_89AB, 16'h0000, 1'b0);
        for (int k = 0; k < 8; k++) begin
            out_ready = 1'b0;
            check($sformatf("m11_l%0d_data", k), 64'(out_data), 64'(seg_exp[k]));
            check($sformatf("m11_l%0d_lane", k), 64'(out_lane), 64'(k));
            check($sformatf("m11_l%0d_last", k), 64'(out_last), 64'(k == 7));
            @(negedge clk);
            check($sformatf("m11_l%0d_hold", k), 64'(out_data), 64'(seg_exp[k]));
            check($sformatf("m11_l%0d_hlane", k), 64'(out_lane), 64'(k));
            out_ready = 1'b1;
            @(negedge clk);
        end
        check("m11_done", 64'(out_valid), 64'd0);
        // mode 10: all unused pairs set to catch a wrong pair pick, then back-to-back word
        push(2'b10, 48'hFFFF_FFFF_FFFF, 16'hFFB7, 1'b1);
        check("m10_l0_ready", 64'(in_ready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("m10_l%0d_data", k), 64'(out_data), 64'(m10_exp[k]));
            check($sformatf("m10_l%0d_lane", k), 64'(out_lane), 64'(k));
            if (k < 3) @(negedge clk);
        end
        check("m10_l3_last", 64'(out_last), 64'd1);
        check("b2b_ready", 64'(in_ready), 64'd1);
        push(2'b10, 48'h0000_0000_0005, 16'h0000, 1'b0);
        check("b2b_valid", 64'(out_valid), 64'd1);
        check("b2b_lane", 64'(out_lane), 64'd0);
        check("b2b_data", 64'(out_data), 64'd5);
        repeat (3) @(negedge clk);
        check("b2b_l3_last", 64'(out_last), 64'd1);
        check("b2b_l3_data", 64'(out_data), 64'd0);
        @(negedge clk);
        check("b2b_done", 64'(out_valid), 64'd0);
        // reset during lane 2 of a mode-11 word
        push(2'b11, 48'h0123_4567_89AB, 16'h0000, 1'b0);
        repeat (2) @(negedge clk);
        check("mid_lane", 64'(out_lane), 64'd2);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data", 64'(out_data), 64'd0);
        check("mid_rst_lane", 64'(out_lane), 64'd0);
        check("mid_rst_last", 64'(out_last), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(in_ready), 64'd1);
        push(2'b00, 48'h0000_0000_0123, 16'h0000, 1'b0);
        check("post_rst_lane", 64'(out_lane), 64'd0);
        check("post_rst_data", 64'(out_data), 64'h123);
        check("post_rst_last", 64'(out_last), 64'd1);
        @(negedge clk);
`ifdef SIMD_UNPACK_OVF_CNT_EN
        check("ovf_zero", 64'(ovf_count), 64'd0);
        for (int i = 0; i < 300; i++) push(2'b00, 48'h0, 16'h0, 1'b1);
        @(negedge clk);
        check("ovf_sat", 64'(ovf_count), 64'hFF);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
